graphic_blitter: RTL and testbench
==================================

GRAPHIC_BLITTER -- requirements
Module: graphic_blitter

Interface
REQ-001 Parameter COLOR_WIDTH, default 3, bits per pixel.
REQ-002 Parameter FB_WIDTH, default 400, pixels per row.
REQ-003 Parameter FB_HEIGHT, default 300, rows.
REQ-004 Parameter COORD_WIDTH, default 16, width of every coordinate and size field.
REQ-005 Parameter ADDR_WIDTH, default 17, framebuffer address width; it SHALL hold FB_WIDTH*FB_HEIGHT-1.
REQ-006 Clk  in  1  sole clock; all logic on the rising edge.
REQ-007 Rst  in  1  asynchronous, active-low reset.
REQ-008 CmdValid  in  1 / CmdReady  out  1: command handshake; a command is accepted on a cycle where both are high.
REQ-009 CmdOp  in  3: 0 NOP, 1 FILL, 2 COPY, 3 KEYCOPY, 4 XORFILL, 5 GET; 6-7 illegal.
REQ-010 CmdColor  in  COLOR_WIDTH: fill colour, XOR mask, or KEYCOPY transparent key.
REQ-011 CmdSrcX, CmdSrcY, CmdDstX, CmdDstY, CmdW, CmdH  in  COORD_WIDTH each: source origin, destination origin, size in pixels.
REQ-012 FbAddr  out  ADDR_WIDTH / FbWe  out  1 / FbRe  out  1 / FbWData  out  COLOR_WIDTH: framebuffer port.
REQ-013 FbRData  in  COLOR_WIDTH: read data, valid the cycle after FbRe.
REQ-014 DataOut  out  COLOR_WIDTH: pixel returned by GET; holds until the next GET.
REQ-015 Done  out  1: one-cycle pulse at command end. Error  out  1: valid with Done.
REQ-016 Busy  out  1: high from acceptance through the Done cycle.

Function
REQ-017 States: IDLE, SETUP, READ, WRITE, DONE. CmdReady SHALL be high only in IDLE.
REQ-018 Acceptance moves IDLE->SETUP and latches every Cmd* field; Cmd* inputs are ignored until IDLE again.
REQ-019 SETUP SHALL check bounds: Error if (DstX+CmdW > FB_WIDTH or DstY+CmdH > FB_HEIGHT), or, for COPY/KEYCOPY, if the same test fails on Src; sums use COORD_WIDTH+1 bits (no wrap). GET checks only Src with W=H=1 and ignores CmdW/CmdH. CmdOp 6-7 SHALL also set Error.
REQ-020 If there is an error, CmdW==0, CmdH==0, or the op is NOP, SETUP->DONE with no framebuffer access.
REQ-021 Addresses: base = Y*FB_WIDTH+X, computed once in SETUP. It is then stepped incrementally by +/-1 within a row and by +/-(FB_WIDTH-W+1) at a row end. No per-pixel multiply.
REQ-022 FILL: WRITE only, one pixel per cycle, FbWe=1, FbWData=CmdColor, raster order from top-left.
REQ-023 XORFILL: READ (FbRe, dst addr) then WRITE (FbWData=FbRData^CmdColor), 2 cycles per pixel.
REQ-024 COPY: READ (FbRe, src addr) then WRITE (dst addr, FbRData), 2 cycles per pixel.
REQ-025 KEYCOPY: as COPY, but a WRITE with FbRData==CmdColor SHALL hold FbWe=0; the cycle is still consumed.
REQ-026 Copy direction: if dst base > src base, traverse backward from bottom-right, right-to-left and bottom-to-top; else forward. Overlapping rectangles SHALL copy exactly as a non-overlapping copy would.
REQ-027 GET: READ at src addr, then WRITE-state capture of FbRData into DataOut with FbWe=0, then DONE.
REQ-028 After the last pixel's WRITE, the next state is DONE. DONE pulses Done, then goes to IDLE.
REQ-029 Latency for a legal W*H FILL accepted at cycle 0: SETUP at cycle 1, writes at cycles 2..W*H+1, Done at W*H+2, CmdReady high at W*H+3. Two-cycle-per-pixel ops have Done at 2*W*H+2.
REQ-030 FbWe and FbRe SHALL never be high together and SHALL be low outside READ/WRITE.
REQ-031 Error is meaningful only while Done=1 and SHALL be 0 otherwise.

Reset
REQ-032 Rst low SHALL immediately force IDLE, CmdReady=1, FbWe=FbRe=0, Done=Error=Busy=0, FbAddr=0, FbWData=0, DataOut=0, independent of Clk.
REQ-033 Reset asserted mid-operation SHALL abort it with no further writes and no Done. The first command after Rst is released SHALL behave as if from power-up.

Verification
REQ-034 FILL Src/Dst=(2,3), W=3, H=2, color 5 -> writes 5 to 1202,1203,1204,1602,1603,1604 on cycles 2-7, Done at cycle 8, Error=0.
REQ-035 COPY src (0,0), dst (1,0), W=4, H=1, row 0 = 1,2,3,4,0 -> backward order, final row 0 = 1,1,2,3,4; Done at cycle 10.
REQ-036 KEYCOPY key 0, src pixels 0,6 -> one write of 6 only; pixel where key matched is unchanged; Done at cycle 6.
REQ-037 FILL DstX=398, W=3 -> no FbWe, Done at cycle 2 with Error=1. CmdOp=7 -> same response.
REQ-038 XORFILL mask 7 on pixel value 2 -> written value 5. GET at the same address -> DataOut=5.
REQ-039 Rst low during the 3rd write of a 6-pixel FILL -> FbWe falls without a clock edge; no Done; CmdReady=1; next FILL completes with normal latency.

Source files
------------

// File: rtl/graphic_blitter.sv
// Rectangle blitter: FILL / XORFILL / COPY / KEYCOPY / GET over a linear framebuffer port.
// Addresses are computed once per command and then stepped, so no per-pixel multiply exists.
module graphic_blitter #(
  parameter int COLOR_WIDTH = 3,
  parameter int FB_WIDTH    = 400,
  parameter int FB_HEIGHT   = 300,
  parameter int COORD_WIDTH = 16,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   CmdValid,
  output logic                   CmdReady,
  input  logic [2:0]             CmdOp,
  input  logic [COLOR_WIDTH-1:0] CmdColor,
  input  logic [COORD_WIDTH-1:0] CmdSrcX,
  input  logic [COORD_WIDTH-1:0] CmdSrcY,
  input  logic [COORD_WIDTH-1:0] CmdDstX,
  input  logic [COORD_WIDTH-1:0] CmdDstY,
  input  logic [COORD_WIDTH-1:0] CmdW,
  input  logic [COORD_WIDTH-1:0] CmdH,
  output logic [ADDR_WIDTH-1:0]  FbAddr,
  output logic                   FbWe,
  output logic                   FbRe,
  output logic [COLOR_WIDTH-1:0] FbWData,
  input  logic [COLOR_WIDTH-1:0] FbRData,
  output logic [COLOR_WIDTH-1:0] DataOut,
  output logic                   Done,
  output logic                   Error,
  output logic                   Busy
);

  // state | meaning
  // IDLE  | waiting for a command, CmdReady high
  // SETUP | bounds check, start addresses, pixel counters
  // READ  | FbRe issued (source, or destination for XORFILL)
  // WRITE | FbWe issued for the pixel; GET captures read data instead
  // DONE  | one-cycle Done pulse, Error qualifies it
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WRITE, S_DONE} state_t;

  localparam int CW = COORD_WIDTH;
  localparam int AW = ADDR_WIDTH;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_FILL    = 3'd1;
  localparam logic [2:0] OP_COPY    = 3'd2;
  localparam logic [2:0] OP_KEYCOPY = 3'd3;
  localparam logic [2:0] OP_XORFILL = 3'd4;
  localparam logic [2:0] OP_GET     = 3'd5;

  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW-1:0] FB_W_A = AW'(FB_WIDTH);
  localparam logic [CW:0]   FB_W_X = (CW+1)'(FB_WIDTH);
  localparam logic [CW:0]   FB_H_X = (CW+1)'(FB_HEIGHT);

  function automatic logic [AW-1:0] lin_addr(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return AW'(y) * FB_W_A + AW'(x);
  endfunction

  // One extra bit on the sums so a huge origin plus size cannot wrap back into range.
  function automatic logic out_of_bounds(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                         input logic [CW-1:0] w, input logic [CW-1:0] h);
    logic [CW:0] x_end;
    logic [CW:0] y_end;
    x_end = {1'b0, x} + {1'b0, w};
    y_end = {1'b0, y} + {1'b0, h};
    return (x_end > FB_W_X) || (y_end > FB_H_X);
  endfunction

  state_t                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  logic [CW-1:0]          sx_q, sx_d, sy_q, sy_d, dx_q, dx_d, dy_q, dy_d;
  logic [CW-1:0]          w_q, w_d, h_q, h_d;
  logic [CW-1:0]          col_q, col_d, row_q, row_d;
  logic [AW-1:0]          src_q, src_d, dst_q, dst_d;
  logic                   back_q, back_d;
  logic                   err_q, err_d;
  logic [COLOR_WIDTH-1:0] data_out_q, data_out_d;

  logic [AW-1:0] src_base, dst_base, far_off, row_step;
  logic          bad_cmd, back_dir;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    color_d    = color_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    row_d      = row_q;
    src_d      = src_q;
    dst_d      = dst_q;
    back_d     = back_q;
    err_d      = err_q;
    data_out_d = data_out_q;

    src_base = lin_addr(sx_q, sy_q);
    dst_base = lin_addr(dx_q, dy_q);
    // Offset from a rectangle's top-left to its bottom-right pixel, shared by src and dst.
    far_off  = AW'(h_q - ONE_C) * FB_W_A + AW'(w_q - ONE_C);
    row_step = FB_W_A - AW'(w_q) + ONE_A;

    case (op_q)
      OP_NOP:                bad_cmd = 1'b0;
      OP_FILL, OP_XORFILL:   bad_cmd = out_of_bounds(dx_q, dy_q, w_q, h_q);
      OP_COPY, OP_KEYCOPY:   bad_cmd = out_of_bounds(dx_q, dy_q, w_q, h_q) ||
                                       out_of_bounds(sx_q, sy_q, w_q, h_q);
      OP_GET:                bad_cmd = out_of_bounds(sx_q, sy_q, ONE_C, ONE_C);
      default:               bad_cmd = 1'b1;
    endcase
    back_dir = ((op_q == OP_COPY) || (op_q == OP_KEYCOPY)) && (dst_base > src_base);

    case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          op_d    = CmdOp;
          color_d = CmdColor;
          sx_d    = CmdSrcX;
          sy_d    = CmdSrcY;
          dx_d    = CmdDstX;
          dy_d    = CmdDstY;
          w_d     = (CmdOp == OP_GET) ? ONE_C : CmdW;
          h_d     = (CmdOp == OP_GET) ? ONE_C : CmdH;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        err_d  = bad_cmd;
        back_d = back_dir;
        src_d  = back_dir ? src_base + far_off : src_base;
        dst_d  = back_dir ? dst_base + far_off : dst_base;
        col_d  = w_q - ONE_C;
        row_d  = h_q - ONE_C;
        if (bad_cmd || (w_q == '0) || (h_q == '0) || (op_q == OP_NOP))
          state_d = S_DONE;
        else if (op_q == OP_FILL)
          state_d = S_WRITE;
        else
          state_d = S_READ;
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        if (op_q == OP_GET) data_out_d = FbRData;
        if (col_q == '0) begin
          if (row_q == '0) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q - ONE_C;
            col_d   = w_q - ONE_C;
            src_d   = back_q ? src_q - row_step : src_q + row_step;
            dst_d   = back_q ? dst_q - row_step : dst_q + row_step;
            state_d = (op_q == OP_FILL) ? S_WRITE : S_READ;
          end
        end else begin
          col_d   = col_q - ONE_C;
          src_d   = back_q ? src_q - ONE_A : src_q + ONE_A;
          dst_d   = back_q ? dst_q - ONE_A : dst_q + ONE_A;
          state_d = (op_q == OP_FILL) ? S_WRITE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      color_q    <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      back_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      color_q    <= color_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      w_q        <= w_d;
      h_q        <= h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      back_q     <= back_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
    end
  end

  // Write data depends on the read returned this very cycle, so it is decoded here.
  logic wr_phase, key_hit;
  assign wr_phase = (state_q == S_WRITE) && (op_q != OP_GET);
  assign key_hit  = (op_q == OP_KEYCOPY) && (FbRData == color_q);

  assign CmdReady = (state_q == S_IDLE);
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_DONE);
  assign Error    = Done && err_q;
  assign FbRe     = (state_q == S_READ);
  assign FbWe     = wr_phase && !key_hit;
  assign FbAddr   = ((state_q == S_READ) && (op_q != OP_XORFILL)) ? src_q : dst_q;
  assign FbWData  = !wr_phase              ? '0 :
                    (op_q == OP_FILL)      ? color_q :
                    (op_q == OP_XORFILL)   ? (FbRData ^ color_q) : FbRData;
  assign DataOut  = data_out_q;

endmodule

// File: tb/tb_graphic_blitter.sv
// Bench for graphic_blitter: framebuffer memory model, directed scenarios and
// randomized commands compared against a rectangle-level reference model.
module tb_graphic_blitter;
  localparam int FBW = 400;
  localparam int FBH = 300;

  logic        Clk, Rst, CmdValid, CmdReady;
  logic [2:0]  CmdOp, CmdColor;
  logic [15:0] CmdSrcX, CmdSrcY, CmdDstX, CmdDstY, CmdW, CmdH;
  logic [16:0] FbAddr;
  logic        FbWe, FbRe;
  logic [2:0]  FbWData, FbRData, DataOut;
  logic        Done, Error, Busy;

  graphic_blitter dut (
    .Clk(Clk), .Rst(Rst), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
    .CmdColor(CmdColor), .CmdSrcX(CmdSrcX), .CmdSrcY(CmdSrcY), .CmdDstX(CmdDstX),
    .CmdDstY(CmdDstY), .CmdW(CmdW), .CmdH(CmdH), .FbAddr(FbAddr), .FbWe(FbWe),
    .FbRe(FbRe), .FbWData(FbWData), .FbRData(FbRData), .DataOut(DataOut),
    .Done(Done), .Error(Error), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [2:0] mem     [0:FBW*FBH-1];
  logic [2:0] ref_mem [0:FBW*FBH-1];
  logic [2:0] exp_dout;
  int wlog_a[$], wlog_d[$], wlog_c[$];
  int cyc_g = 0, wr_total = 0, done_cnt = 0, viol = 0;
  int acc_g;
  int n_chk = 0, n_pass = 0;

  always @(posedge Clk) begin
    if (FbWe) begin
      mem[FbAddr] <= FbWData;
      wlog_a.push_back(int'(FbAddr));
      wlog_d.push_back(int'(FbWData));
      wlog_c.push_back(cyc_g - acc_g);
      wr_total = wr_total + 1;
    end
    if (FbRe) FbRData <= mem[FbAddr];
    if (Done) done_cnt = done_cnt + 1;
    if (FbWe && FbRe) viol = viol + 1;
    if (Error && !Done) viol = viol + 1;
    if (!Busy && (FbWe || FbRe)) viol = viol + 1;
    cyc_g = cyc_g + 1;
  end

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < FBW*FBH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic bit oob(input int x, input int y, input int w, input int h);
    return (x + w > FBW) || (y + h > FBH);
  endfunction

  // Reference: whole-rectangle semantics; copies snapshot the source before writing.
  task automatic ref_apply(input int op, input int color, input int sx, input int sy,
                           input int dx, input int dy, input int w, input int h,
                           output logic e, output int dcyc, output int nwr);
    logic [2:0] tmp[$];
    int k, a;
    case (op)
      0:       e = 1'b0;
      1, 4:    e = oob(dx, dy, w, h);
      2, 3:    e = oob(dx, dy, w, h) || oob(sx, sy, w, h);
      5:       e = oob(sx, sy, 1, 1);
      default: e = 1'b1;
    endcase
    dcyc = 2;
    nwr  = 0;
    if (e || op == 0 || (op != 5 && (w == 0 || h == 0))) return;
    if (op == 5) begin
      exp_dout = ref_mem[sy*FBW + sx];
      dcyc = 4;
      return;
    end
    if (op == 2 || op == 3)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) tmp.push_back(ref_mem[(sy+y)*FBW + sx + x]);
    k = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        a = (dy+y)*FBW + dx + x;
        case (op)
          1: begin ref_mem[a] = 3'(color); nwr++; end
          4: begin ref_mem[a] = ref_mem[a] ^ 3'(color); nwr++; end
          2: begin ref_mem[a] = tmp[k]; nwr++; end
          default: if (tmp[k] != 3'(color)) begin ref_mem[a] = tmp[k]; nwr++; end
        endcase
        k++;
      end
    dcyc = (op == 1) ? w*h + 2 : 2*w*h + 2;
  endtask

  task automatic run_cmd(input int op, input int color, input int sx, input int sy,
                         input int dx, input int dy, input int w, input int h,
                         output int done_cyc, output logic err, output int nwr);
    int start_wr;
    @(negedge Clk);
    CmdValid = 1'b1; CmdOp = 3'(op); CmdColor = 3'(color);
    CmdSrcX = 16'(sx); CmdSrcY = 16'(sy); CmdDstX = 16'(dx); CmdDstY = 16'(dy);
    CmdW = 16'(w); CmdH = 16'(h);
    wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
    acc_g = cyc_g;
    start_wr = wr_total;
    @(posedge Clk);
    @(negedge Clk);
    // Scramble the command inputs: the block must be working from its latched copy.
    CmdValid = 1'b0; CmdOp = 3'($urandom); CmdColor = 3'($urandom);
    CmdSrcX = 16'($urandom); CmdDstX = 16'($urandom); CmdW = 16'($urandom); CmdH = 16'($urandom);
    done_cyc = -1;
    err = 1'bx;
    for (int k = 1; k <= 3000; k++) begin
      if (Done === 1'b1) begin
        done_cyc = k;
        err = Error;
        break;
      end
      @(negedge Clk);
    end
    nwr = wr_total - start_wr;
  endtask

  task automatic put_px(input int x, input int y, input int c);
    logic e; int d, n;
    ref_apply(1, c, 0, 0, x, y, 1, 1, e, d, n);
    run_cmd(1, c, 0, 0, x, y, 1, 1, d, e, n);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge Clk);
    n_chk++; if (CmdReady !== 1'b1) $display("FAIL reset_ready: got %b want 1", CmdReady); else n_pass++;
    n_chk++; if ({Busy, Done, Error, FbWe, FbRe} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {Busy, Done, Error, FbWe, FbRe}); else n_pass++;
    n_chk++; if (FbAddr !== 17'd0 || DataOut !== 3'd0 || FbWData !== 3'd0) $display("FAIL reset_data: got addr %0d dout %0d wdata %0d want 0", FbAddr, DataOut, FbWData); else n_pass++;
    Rst = 1'b1;
    @(negedge Clk);
    n_chk++; if (CmdReady !== 1'b1 || Busy !== 1'b0) $display("FAIL post_reset_idle: got ready %b busy %b want 1 0", CmdReady, Busy); else n_pass++;
  endtask

  task automatic test_fill_example;
    logic e, ee; int d, n, ed, en;
    int ea[6] = '{1202, 1203, 1204, 1602, 1603, 1604};
    ref_apply(1, 5, 2, 3, 2, 3, 3, 2, ee, ed, en);
    run_cmd(1, 5, 2, 3, 2, 3, 3, 2, d, e, n);
    n_chk++; if (d !== 8 || e !== 1'b0) $display("FAIL fill_done: got cyc %0d err %b want 8 0", d, e); else n_pass++;
    n_chk++; if (wlog_a.size() != 6) $display("FAIL fill_nwr: got %0d want 6", wlog_a.size()); else n_pass++;
    for (int i = 0; i < 6 && i < wlog_a.size(); i++) begin
      n_chk++;
      if (wlog_a[i] != ea[i] || wlog_d[i] != 5 || wlog_c[i] != i + 2)
        $display("FAIL fill_write%0d: got addr %0d data %0d cyc %0d want %0d 5 %0d", i, wlog_a[i], wlog_d[i], wlog_c[i], ea[i], i + 2);
      else n_pass++;
    end
    n_chk++; if (mem_diff() != 0) $display("FAIL fill_mem: got %0d diffs want 0", mem_diff()); else n_pass++;
  endtask

  task automatic test_copy_overlap;
    logic e, ee; int d, n, ed, en;
    int ea[4] = '{4, 3, 2, 1};
    put_px(0, 0, 1); put_px(1, 0, 2); put_px(2, 0, 3); put_px(3, 0, 4); put_px(4, 0, 0);
    ref_apply(2, 0, 0, 0, 1, 0, 4, 1, ee, ed, en);
    run_cmd(2, 0, 0, 0, 1, 0, 4, 1, d, e, n);
    n_chk++; if (d !== 10 || e !== 1'b0) $display("FAIL copy_done: got cyc %0d err %b want 10 0", d, e); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= wlog_a.size() || wlog_a[i] != ea[i]) $display("FAIL copy_order%0d: got %0d want %0d", i, (i < wlog_a.size()) ? wlog_a[i] : -1, ea[i]);
      else n_pass++;
    end
    n_chk++; if ({mem[0], mem[1], mem[2], mem[3], mem[4]} !== {3'd1, 3'd1, 3'd2, 3'd3, 3'd4}) $display("FAIL copy_row: got %0d %0d %0d %0d %0d want 1 1 2 3 4", mem[0], mem[1], mem[2], mem[3], mem[4]); else n_pass++;
  endtask

  task automatic test_keycopy;
    logic e, ee; int d, n, ed, en;
    put_px(10, 10, 0); put_px(11, 10, 6); put_px(10, 11, 3); put_px(11, 11, 3);
    ref_apply(3, 0, 10, 10, 10, 11, 2, 1, ee, ed, en);
    run_cmd(3, 0, 10, 10, 10, 11, 2, 1, d, e, n);
    n_chk++; if (d !== 6 || e !== 1'b0) $display("FAIL key_done: got cyc %0d err %b want 6 0", d, e); else n_pass++;
    n_chk++; if (n != 1 || wlog_a.size() != 1 || wlog_a[0] != 11*FBW + 11 || wlog_d[0] != 6) $display("FAIL key_write: got %0d writes want 1 write of 6 to %0d", n, 11*FBW + 11); else n_pass++;
    n_chk++; if (mem[11*FBW + 10] !== 3'd3) $display("FAIL key_hold: got %0d want 3", mem[11*FBW + 10]); else n_pass++;
  endtask

  task automatic test_errors;
    logic e; int d, n;
    run_cmd(1, 1, 0, 0, 398, 0, 3, 1, d, e, n);
    n_chk++; if (d !== 2 || e !== 1'b1 || n != 0) $display("FAIL err_bounds: got cyc %0d err %b writes %0d want 2 1 0", d, e, n); else n_pass++;
    run_cmd(7, 1, 0, 0, 5, 5, 2, 2, d, e, n);
    n_chk++; if (d !== 2 || e !== 1'b1 || n != 0) $display("FAIL err_op7: got cyc %0d err %b writes %0d want 2 1 0", d, e, n); else n_pass++;
    run_cmd(1, 1, 0, 0, 5, 5, 0, 2, d, e, n);
    n_chk++; if (d !== 2 || e !== 1'b0 || n != 0) $display("FAIL zero_w: got cyc %0d err %b writes %0d want 2 0 0", d, e, n); else n_pass++;
    run_cmd(0, 1, 0, 0, 5, 5, 2, 2, d, e, n);
    n_chk++; if (d !== 2 || e !== 1'b0 || n != 0) $display("FAIL nop: got cyc %0d err %b writes %0d want 2 0 0", d, e, n); else n_pass++;
  endtask

  task automatic test_xor_get;
    logic e, ee; int d, n, ed, en;
    put_px(20, 5, 2);
    ref_apply(4, 7, 0, 0, 20, 5, 1, 1, ee, ed, en);
    run_cmd(4, 7, 0, 0, 20, 5, 1, 1, d, e, n);
    n_chk++; if (d !== 4 || mem[5*FBW + 20] !== 3'd5) $display("FAIL xor: got cyc %0d pixel %0d want 4 5", d, mem[5*FBW + 20]); else n_pass++;
    ref_apply(5, 0, 20, 5, 0, 0, 0, 0, ee, ed, en);
    run_cmd(5, 0, 20, 5, 0, 0, 0, 0, d, e, n);
    n_chk++; if (d !== 4 || DataOut !== 3'd5 || n != 0) $display("FAIL get: got cyc %0d dout %0d writes %0d want 4 5 0", d, DataOut, n); else n_pass++;
  endtask

  task automatic test_reset_midop;
    logic e, ee; int d, n, ed, en, start_done, start_wr;
    @(negedge Clk);
    CmdValid = 1'b1; CmdOp = 3'd1; CmdColor = 3'd4;
    CmdDstX = 16'd50; CmdDstY = 16'd50; CmdW = 16'd3; CmdH = 16'd2;
    start_done = done_cnt;
    start_wr = wr_total;
    @(posedge Clk);
    @(negedge Clk);
    CmdValid = 1'b0;
    repeat (3) @(negedge Clk);
    n_chk++; if (FbWe !== 1'b1) $display("FAIL mid_third_write: got FbWe %b want 1", FbWe); else n_pass++;
    #1 Rst = 1'b0;
    #1;
    n_chk++; if (FbWe !== 1'b0 || CmdReady !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) $display("FAIL async_reset: got we %b ready %b busy %b done %b want 0 1 0 0", FbWe, CmdReady, Busy, Done); else n_pass++;
    n_chk++; if (FbAddr !== 17'd0 || FbWData !== 3'd0 || DataOut !== 3'd0) $display("FAIL async_reset_data: got addr %0d wdata %0d dout %0d want 0", FbAddr, FbWData, DataOut); else n_pass++;
    exp_dout = 3'd0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    ref_mem[50*FBW + 50] = 3'd4;
    ref_mem[50*FBW + 51] = 3'd4;
    n_chk++; if (done_cnt != start_done || wr_total - start_wr != 2) $display("FAIL abort: got done %0d writes %0d want 0 2", done_cnt - start_done, wr_total - start_wr); else n_pass++;
    ref_apply(1, 6, 0, 0, 100, 100, 3, 2, ee, ed, en);
    run_cmd(1, 6, 0, 0, 100, 100, 3, 2, d, e, n);
    n_chk++; if (d !== 8 || e !== 1'b0 || n != 6) $display("FAIL after_reset_fill: got cyc %0d err %b writes %0d want 8 0 6", d, e, n); else n_pass++;
    n_chk++; if (mem_diff() != 0) $display("FAIL after_reset_mem: got %0d diffs want 0", mem_diff()); else n_pass++;
  endtask

  function automatic int rnd_x();
    return ($urandom_range(0, 7) == 0) ? 390 + $urandom_range(0, 9) : $urandom_range(0, 24);
  endfunction
  function automatic int rnd_y();
    return ($urandom_range(0, 7) == 0) ? 292 + $urandom_range(0, 7) : $urandom_range(0, 12);
  endfunction

  task automatic test_random;
    logic e, ee; int d, n, ed, en, op, c, sx, sy, dx, dy, w, h;
    for (int t = 0; t < 30; t++) begin
      op = $urandom_range(0, 7); c = $urandom_range(0, 7);
      sx = rnd_x(); sy = rnd_y(); dx = rnd_x(); dy = rnd_y();
      w = $urandom_range(0, 7); h = $urandom_range(0, 4);
      ref_apply(op, c, sx, sy, dx, dy, w, h, ee, ed, en);
      run_cmd(op, c, sx, sy, dx, dy, w, h, d, e, n);
      n_chk++; if (d !== ed || e !== ee) $display("FAIL rnd%0d_done op%0d: got cyc %0d err %b want %0d %b", t, op, d, e, ed, ee); else n_pass++;
      n_chk++; if (n != en) $display("FAIL rnd%0d_writes op%0d: got %0d want %0d", t, op, n, en); else n_pass++;
      n_chk++; if (DataOut !== exp_dout) $display("FAIL rnd%0d_dout: got %0d want %0d", t, DataOut, exp_dout); else n_pass++;
      n_chk++; if (mem_diff() != 0) $display("FAIL rnd%0d_mem op%0d: got %0d diffs want 0", t, op, mem_diff()); else n_pass++;
    end
  endtask

  task automatic test_invariants;
    n_chk++; if (viol != 0) $display("FAIL port_invariants: got %0d violations want 0", viol); else n_pass++;
  endtask

  initial begin
    Rst = 1'b0; CmdValid = 1'b0; CmdOp = '0; CmdColor = '0;
    CmdSrcX = '0; CmdSrcY = '0; CmdDstX = '0; CmdDstY = '0; CmdW = '0; CmdH = '0;
    exp_dout = 3'd0;
    for (int i = 0; i < FBW*FBH; i++) begin
      mem[i] = 3'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_fill_example();
    test_copy_overlap();
    test_keycopy();
    test_errors();
    test_xor_get();
    test_reset_midop();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
